// File: rtl/muldiv_pkg.sv
// Shared state encoding and operation constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction and final sign correction for muldiv_unit.
// Purely combinational; unsigned operation is selected by sign=0.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sign,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  input  logic             neg_res,
  input  logic             neg_rem,
  output logic             a_neg_c,
  output logic             b_neg_c,
  output logic [WIDTH-1:0] a_mag_c,
  output logic [WIDTH-1:0] b_mag_c,
  output logic [WIDTH-1:0] fix_hi_c,
  output logic [WIDTH-1:0] fix_lo_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] prod_neg;

  // Operand magnitudes; the most-negative value maps onto itself as an unsigned magnitude
  always_comb begin
    a_neg_c = sign & a[WIDTH-1];
    b_neg_c = sign & b[WIDTH-1];
    a_mag_c = a_neg_c ? (~a + WIDTH'(1)) : a;
    b_mag_c = b_neg_c ? (~b + WIDTH'(1)) : b;
  end

  // Result correction: full-width negate for products, per-half negate for quotient/remainder
  always_comb begin
    prod     = {raw_hi, raw_lo};
    prod_neg = ~prod + PW'(1);
    fix_hi_c = raw_hi;
    fix_lo_c = raw_lo;
    if (div) begin
      fix_lo_c = neg_res ? (~raw_lo + WIDTH'(1)) : raw_lo;
      fix_hi_c = neg_rem ? (~raw_hi + WIDTH'(1)) : raw_hi;
    end else if (neg_res) begin
      {fix_hi_c, fix_lo_c} = prod_neg;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_FASTMUL_EN to compute multiplies in a single MUL cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             annul,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             neg_res;
  logic             neg_rem;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;
  logic             last_c;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] fix_hi_c;
  logic [WIDTH-1:0] fix_lo_c;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .sign     (sign),
    .div      (state == DIV),
    .a        (a),
    .b        (b),
    .raw_hi   (raw_hi),
    .raw_lo   (raw_lo),
    .neg_res  (neg_res),
    .neg_rem  (neg_rem),
    .a_neg_c  (a_neg_c),
    .b_neg_c  (b_neg_c),
    .a_mag_c  (a_mag_c),
    .b_mag_c  (b_mag_c),
    .fix_hi_c (fix_hi_c),
    .fix_lo_c (fix_lo_c)
  );

  // One iteration: multiply shifts {acc_hi,acc_lo} right after a conditional add,
  // divide shifts the dividend bit into the partial remainder and trial-subtracts
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (state == DIV) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef MULDIV_FASTMUL_EN
  localparam int unsigned PW = 2 * WIDTH;
  logic [PW-1:0] fast_prod;

  assign fast_prod = PW'(opnd) * PW'(acc_lo);
  assign last_c    = (state == MUL) || (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    raw_hi = step_hi;
    raw_lo = step_lo;
    if (state == MUL) {raw_hi, raw_lo} = fast_prod;
  end
`else
  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    raw_hi = step_hi;
    raw_lo = step_lo;
  end
`endif

  // Control FSM with registered outputs; hi/lo only ever change on the edge that raises done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            neg_res  <= a_neg_c ^ b_neg_c;
            neg_rem  <= a_neg_c;
            if (op_div == OP_MUL) begin
              state  <= MUL;
              acc_lo <= b_mag_c;
              opnd   <= a_mag_c;
            end else if (b == '0) begin
              state    <= FIN;
              done     <= 1'b1;
              hi       <= a;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              state  <= DIV;
              acc_lo <= a_mag_c;
              opnd   <= b_mag_c;
            end
          end
        end
        MUL, DIV: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (last_c) begin
              state <= FIN;
              done  <= 1'b1;
              hi    <= fix_hi_c;
              lo    <= fix_lo_c;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, operand/result width; legal values are even and at least 4.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 annul  input  1  cancel the in-flight operation.
REQ-006 op_div  input  1  1 = divide, 0 = multiply; sampled with start.
REQ-007 sign  input  1  1 = signed, 0 = unsigned; sampled with start.
REQ-008 a  input  WIDTH  multiplicand/dividend; sampled with start.
REQ-009 b  input  WIDTH  multiplier/divisor; sampled with start.
REQ-010 busy  output  1  high while an operation is in flight; pipeline stall source.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 hi  output  WIDTH  product upper half / remainder.
REQ-013 lo  output  WIDTH  product lower half / quotient.
REQ-014 div_zero  output  1  set with done when divisor was zero; held until next accepted start.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV and FIN.
- IDLE->MUL/DIV on start & !annul.
- MUL/DIV->FIN after WIDTH iteration cycles.
- FIN->IDLE unconditionally.
REQ-016 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per cycle; the sign is applied in FIN when sign=1.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes.
- Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-018 done SHALL pulse in the cycle FIN is occupied, which is the (WIDTH+1)th cycle after the start cycle; hi/lo update on that same edge.
REQ-019 hi/lo SHALL hold their last result until the next done; they are never disturbed by annul.
REQ-020 busy SHALL be high in MUL, DIV and FIN, and low in IDLE.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 annul in MUL/DIV/FIN SHALL return to IDLE on the next edge with no done pulse; annul and start in the same IDLE cycle SHALL leave the block in IDLE.
REQ-023 A divisor of zero SHALL skip iteration and go straight to FIN (done in the 1st cycle after start) with hi=a, lo=all-ones, div_zero=1.
REQ-024 Signed most-negative/-1 SHALL wrap: lo=most-negative value, hi=0, div_zero=0.
REQ-025 All arithmetic SHALL be modulo 2^WIDTH per half; the product SHALL be the full 2*WIDTH bits.

Reset
REQ-026 On reset the block SHALL enter IDLE with busy=0, done=0, div_zero=0, hi=0, lo=0 and all internal registers zeroed.
REQ-027 Reset asserted mid-operation SHALL abort immediately; no done is produced after release.

Configuration
REQ-028 With macro MULDIV_FASTMUL_EN defined, multiply SHALL compute combinationally in one MUL cycle, giving done in the 2nd cycle after start; divide is unchanged.
REQ-029 Without MULDIV_FASTMUL_EN, multiply SHALL be iterative per REQ-016 and REQ-018.

Structure
REQ-030 Package muldiv_pkg SHALL hold the state typedef (IDLE/MUL/DIV/FIN) and the OP_MUL/OP_DIV constants.
REQ-031 Magnitude extraction and final sign correction SHALL reside in a single sub-module, muldiv_signfix, parametrised by WIDTH.
REQ-032 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32, MULDIV_FASTMUL_EN undefined unless stated)
REQ-033 Unsigned mult 0xFFFFFFFF*0x2 -> done in the 33rd cycle after start, hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 Signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-035 Div 5/0 -> done in the 1st cycle after start, hi=0x00000005, lo=0xFFFFFFFF, div_zero=1.
REQ-036 Annul on the 10th cycle of a mult -> busy low on the next cycle, no done, hi/lo keep their prior values; start raised while busy is ignored.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; with MULDIV_FASTMUL_EN, signed mult -3*5 -> done in the 2nd cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 rst_n pulsed low mid-divide -> outputs are zero immediately, and no done follows.
